// File: rtl/adda_pll_ctrl.sv
// Power-up, lock-qualification and relock sequencer for the ADDA PLL.
// Runs on the PLL reference clock; every output is a registered decode of the next state.
module adda_pll_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       relock_req,
  input  logic       pll_lock,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic       rstodiv,
  output logic       adda_rst,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWR_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic             lock_m, lock_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (!enable) begin
      state_d = S_OFF;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_PWR_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
        S_PWR_RST: begin
          if (relock_req) begin
            cnt_d   = '0;
            retry_d = '0;
          end else if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (relock_req) begin
            state_d = S_PWR_RST;
            cnt_d   = '0;
            retry_d = '0;
          end else if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_PWR_RST;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          // A drop here only restarts the lock wait; it does not consume a retry
          if (relock_req) begin
            state_d = S_PWR_RST;
            cnt_d   = '0;
            retry_d = '0;
          end else if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          // A lock loss is counted even when a relock request arrives in the same cycle
          if (!lock_s && lost_q != 8'hFF) begin
            lost_d = lost_q + 1'b1;
          end
          if (relock_req || !lock_s) begin
            state_d = S_PWR_RST;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        S_FAIL: begin
          if (relock_req) begin
            state_d = S_PWR_RST;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      state_q   <= S_OFF;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_pwd   <= 1'b1;
      pll_rst   <= 1'b1;
      rstodiv   <= 1'b1;
      adda_rst  <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      lock_m    <= pll_lock;
      lock_s    <= lock_m;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_pwd   <= (state_d == S_OFF) || (state_d == S_FAIL);
      pll_rst   <= (state_d == S_OFF) || (state_d == S_FAIL) || (state_d == S_PWR_RST);
      rstodiv   <= (state_d != S_RUN);
      adda_rst  <= (state_d != S_RUN);
      locked    <= (state_d == S_RUN);
      fail      <= (state_d == S_FAIL);
    end
  end

  assign retry_cnt = retry_q;
  assign lost_cnt  = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_adda_pll_ctrl.sv
// Directed self-checking bench for adda_pll_ctrl with short sequencing parameters.
// Inputs change 1 time unit after a rising edge and outputs are sampled at the same point.
module tb_adda_pll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_pwd, pll_rst, rstodiv, adda_rst, locked, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  adda_pll_ctrl #(
    .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .relock_req(relock_req), .pll_lock(pll_lock),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .rstodiv(rstodiv), .adda_rst(adda_rst),
    .locked(locked), .fail(fail), .retry_cnt(retry_cnt), .lost_cnt(lost_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; relock_req = 1'b0; pll_lock = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if ({pll_pwd, pll_rst, rstodiv, adda_rst, locked, fail} !== 6'b111100) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected 111100", {pll_pwd, pll_rst, rstodiv, adda_rst, locked, fail});
    end
    checks++;
    if ({retry_cnt, lost_cnt} !== 12'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", retry_cnt, lost_cnt); end
  endtask

  // PWR_RST lasts exactly 4 cycles, then lock qualifies 2 sync + 8 stable cycles later
  task automatic test_lock_sequence();
    enable = 1'b1;
    tick(1);
    checks++;
    if ({state, pll_pwd, pll_rst, rstodiv, adda_rst} !== {3'd1, 4'b0111}) begin
      errors++; $display("[TB] FAIL pwr_rst_entry: got %0d/%b expected 1/0111", state, {pll_pwd, pll_rst, rstodiv, adda_rst});
    end
    tick(3);
    checks++;
    if ({state, pll_rst} !== {3'd1, 1'b1}) begin errors++; $display("[TB] FAIL pwr_rst_4th: got %0d/%b expected 1/1", state, pll_rst); end
    tick(1);
    checks++;
    if ({state, pll_pwd, pll_rst, rstodiv, adda_rst} !== {3'd2, 4'b0011}) begin
      errors++; $display("[TB] FAIL wait_lock_entry: got %0d/%b expected 2/0011", state, {pll_pwd, pll_rst, rstodiv, adda_rst});
    end
    pll_lock = 1'b1;
    tick(2);
    checks++;
    if (state !== 3'd2) begin errors++; $display("[TB] FAIL sync_latency: got %0d expected 2", state); end
    tick(1);
    checks++;
    if (state !== 3'd3) begin errors++; $display("[TB] FAIL stable_entry: got %0d expected 3", state); end
    tick(7);
    checks++;
    if ({state, locked, adda_rst} !== {3'd3, 1'b0, 1'b1}) begin
      errors++; $display("[TB] FAIL stable_last: got %0d/%b/%b expected 3/0/1", state, locked, adda_rst);
    end
    tick(1);
    checks++;
    if ({state, locked, adda_rst, rstodiv, retry_cnt} !== {3'd4, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++; $display("[TB] FAIL run_entry: got %0d/%b/%b/%b/%0d expected 4/1/0/0/0", state, locked, adda_rst, rstodiv, retry_cnt);
    end
  endtask

  task automatic test_retry_fail();
    do_reset();
    enable = 1'b1;
    tick(1);
    tick(4);
    checks++;
    if ({state, retry_cnt} !== {3'd2, 4'd0}) begin errors++; $display("[TB] FAIL try0_wait: got %0d/%0d expected 2/0", state, retry_cnt); end
    tick(31);
    checks++;
    if (state !== 3'd2) begin errors++; $display("[TB] FAIL try0_timeout_edge: got %0d expected 2", state); end
    tick(1);
    checks++;
    if ({state, retry_cnt} !== {3'd1, 4'd1}) begin errors++; $display("[TB] FAIL retry1: got %0d/%0d expected 1/1", state, retry_cnt); end
    tick(36);
    checks++;
    if ({state, retry_cnt} !== {3'd1, 4'd2}) begin errors++; $display("[TB] FAIL retry2: got %0d/%0d expected 1/2", state, retry_cnt); end
    tick(35);
    checks++;
    if (state !== 3'd2) begin errors++; $display("[TB] FAIL try2_last_wait: got %0d expected 2", state); end
    tick(1);
    checks++;
    if ({state, fail, pll_pwd, pll_rst, adda_rst, locked, retry_cnt} !== {3'd5, 4'b1111, 1'b0, 4'd2}) begin
      errors++; $display("[TB] FAIL fail_entry: got %0d/%b/%b/%b/%b/%b/%0d expected 5/1/1/1/1/0/2",
                        state, fail, pll_pwd, pll_rst, adda_rst, locked, retry_cnt);
    end
    tick(5);
    checks++;
    if ({state, retry_cnt} !== {3'd5, 4'd2}) begin errors++; $display("[TB] FAIL fail_hold: got %0d/%0d expected 5/2", state, retry_cnt); end
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if ({state, retry_cnt, fail, pll_pwd} !== {3'd1, 4'd0, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL fail_relock: got %0d/%0d/%b/%b expected 1/0/0/0", state, retry_cnt, fail, pll_pwd);
    end
  endtask

  // Lock drops after 5 synchronized cycles in STABLE; RUN needs a fresh uninterrupted 8
  task automatic test_glitch();
    do_reset();
    enable = 1'b1;
    tick(5);
    pll_lock = 1'b1;
    tick(3);
    checks++;
    if (state !== 3'd3) begin errors++; $display("[TB] FAIL glitch_stable: got %0d expected 3", state); end
    tick(4);
    pll_lock = 1'b0;
    tick(3);
    checks++;
    if ({state, locked, retry_cnt} !== {3'd2, 1'b0, 4'd0}) begin
      errors++; $display("[TB] FAIL glitch_back_to_wait: got %0d/%b/%0d expected 2/0/0", state, locked, retry_cnt);
    end
    pll_lock = 1'b1;
    tick(3);
    checks++;
    if (state !== 3'd3) begin errors++; $display("[TB] FAIL glitch_restable: got %0d expected 3", state); end
    tick(7);
    checks++;
    if (state !== 3'd3) begin errors++; $display("[TB] FAIL glitch_not_early: got %0d expected 3", state); end
    tick(1);
    checks++;
    if ({state, locked, retry_cnt} !== {3'd4, 1'b1, 4'd0}) begin
      errors++; $display("[TB] FAIL glitch_run: got %0d/%b/%0d expected 4/1/0", state, locked, retry_cnt);
    end
  endtask

  // Starts in RUN with lock held high
  task automatic test_lock_loss();
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    checks++;
    if ({state, adda_rst} !== {3'd4, 1'b0}) begin errors++; $display("[TB] FAIL loss_still_run: got %0d/%b expected 4/0", state, adda_rst); end
    tick(1);
    checks++;
    if ({state, adda_rst, locked, lost_cnt, retry_cnt} !== {3'd1, 1'b1, 1'b0, 8'd1, 4'd0}) begin
      errors++; $display("[TB] FAIL loss_pwr_rst: got %0d/%b/%b/%0d/%0d expected 1/1/0/1/0", state, adda_rst, locked, lost_cnt, retry_cnt);
    end
    tick(13);
    checks++;
    if ({state, lost_cnt} !== {3'd4, 8'd1}) begin errors++; $display("[TB] FAIL loss_relocked: got %0d/%0d expected 4/1", state, lost_cnt); end
  endtask

  task automatic test_enable_relock();
    enable = 1'b0;
    tick(1);
    checks++;
    if ({state, pll_pwd, pll_rst, rstodiv, adda_rst, locked} !== {3'd0, 5'b11110}) begin
      errors++; $display("[TB] FAIL disable_off: got %0d/%b expected 0/11110", state, {pll_pwd, pll_rst, rstodiv, adda_rst, locked});
    end
    enable = 1'b1;
    tick(1);
    tick(13);
    checks++;
    if ({state, lost_cnt} !== {3'd4, 8'd1}) begin errors++; $display("[TB] FAIL reenable_run: got %0d/%0d expected 4/1", state, lost_cnt); end
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if ({state, lost_cnt, adda_rst} !== {3'd1, 8'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL run_relock: got %0d/%0d/%b expected 1/1/1", state, lost_cnt, adda_rst);
    end
    tick(13);
  endtask

  task automatic test_back_to_back();
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if ({state, lost_cnt, retry_cnt} !== {3'd1, 8'd2, 4'd0}) begin
      errors++; $display("[TB] FAIL drop_and_relock: got %0d/%0d/%0d expected 1/2/0", state, lost_cnt, retry_cnt);
    end
    tick(13);
    checks++;
    if (state !== 3'd4) begin errors++; $display("[TB] FAIL drop_and_relock_run: got %0d expected 4", state); end
  endtask

  task automatic test_rst_mid_wait();
    pll_lock = 1'b0;
    tick(3);
    tick(36);
    tick(4);
    tick(5);
    checks++;
    if ({state, retry_cnt, lost_cnt} !== {3'd2, 4'd1, 8'd3}) begin
      errors++; $display("[TB] FAIL mid_wait_setup: got %0d/%0d/%0d expected 2/1/3", state, retry_cnt, lost_cnt);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({state, retry_cnt, lost_cnt, pll_pwd, pll_rst, rstodiv, adda_rst, locked, fail} !== {3'd0, 4'd0, 8'd0, 6'b111100}) begin
      errors++; $display("[TB] FAIL rst_mid_wait: got %0d/%0d/%0d/%b expected 0/0/0/111100",
                        state, retry_cnt, lost_cnt, {pll_pwd, pll_rst, rstodiv, adda_rst, locked, fail});
    end
    tick(4);
    checks++;
    if (state !== 3'd1) begin errors++; $display("[TB] FAIL rst_counter_cleared: got %0d expected 1", state); end
    tick(1);
    checks++;
    if (state !== 3'd2) begin errors++; $display("[TB] FAIL rst_pwr_rst_len: got %0d expected 2", state); end
  endtask

  task automatic lose_lock_once();
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(15);
  endtask

  task automatic test_saturation();
    int budget;
    pll_lock = 1'b1;
    budget = 0;
    while (state !== 3'd4 && budget < 100) begin
      tick(1);
      budget++;
    end
    checks++;
    if (state !== 3'd4) begin errors++; $display("[TB] FAIL sat_reach_run: got %0d expected 4", state); end
    for (int i = 0; i < 255; i++) lose_lock_once();
    checks++;
    if ({state, lost_cnt} !== {3'd4, 8'd255}) begin errors++; $display("[TB] FAIL sat_255: got %0d/%0d expected 4/255", state, lost_cnt); end
    for (int i = 0; i < 45; i++) lose_lock_once();
    checks++;
    if ({state, lost_cnt} !== {3'd4, 8'd255}) begin errors++; $display("[TB] FAIL sat_hold: got %0d/%0d expected 4/255", state, lost_cnt); end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_retry_fail();
    test_glitch();
    test_lock_loss();
    test_enable_relock();
    test_back_to_back();
    test_rst_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
